// File: rtl/rr_merge_sched_if.sv
// rtl/rr_merge_sched_if.sv - requester and merged-output channels of rr_merge_sched
interface rr_merge_sched_if #(
    parameter int N = 2,
    parameter int W = 128
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_enq_ena;
    logic [N*W-1:0] in_enq_v;
    logic [N-1:0]   in_enq_rdy;
    logic           out_enq_ena;
    logic [W-1:0]   out_enq_v;
    logic [SW-1:0]  out_src;
    logic           out_enq_rdy;

    modport master (
        output in_enq_ena, in_enq_v, out_enq_rdy,
        input  in_enq_rdy, out_enq_ena, out_enq_v, out_src
    );

    modport slave (
        input  in_enq_ena, in_enq_v, out_enq_rdy,
        output in_enq_rdy, out_enq_ena, out_enq_v, out_src
    );
endinterface

// File: rtl/rr_merge_sched.sv
// rtl/rr_merge_sched.sv - round-robin merge of N requester FIFOs onto one registered output
// Define RR_MERGE_PRIO0_EN to give requester 0 strict priority over the round-robin.
module rr_merge_sched #(
    parameter int N     = 2,
    parameter int W     = 128,
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    rr_merge_sched_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_EMPTY, ST_VALID} state_e;

    logic [W-1:0]  mem_q  [N][DEPTH];
    logic [PW-1:0] wptr_q [N];
    logic [PW-1:0] rptr_q [N];
    logic [CW-1:0] cnt_q  [N];
    logic [SW-1:0] ptr_q;
    state_e        state_q;
    logic [W-1:0]  data_q;
    logic [SW-1:0] src_q;

    logic [N-1:0]  nonempty;
    logic [N-1:0]  rdy;
    logic [N-1:0]  enq;
    logic          load;
    logic          found;
    logic          prio_hit;
    logic          deq;
    logic [SW-1:0] win;
    logic [SW-1:0] idx;
    logic [SW-1:0] ptr_d;
    logic [W-1:0]  head;

    always_comb begin
        nonempty = '0;
        rdy      = '0;
        enq      = '0;
        found    = 1'b0;
        prio_hit = 1'b0;
        win      = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            // RDY is held low during reset so nothing is accepted into a clearing FIFO
            rdy[i]      = ~rst & (cnt_q[i] != CW'(DEPTH));
            enq[i]      = bus.in_enq_ena[i] & rdy[i];
        end
        load = (state_q == ST_EMPTY) | bus.out_enq_rdy;
`ifdef RR_MERGE_PRIO0_EN
        if (nonempty[0]) begin
            found    = 1'b1;
            prio_hit = 1'b1;
        end
`endif
        for (int k = 0; k < N; k++) begin
            idx = SW'((int'(ptr_q) + k) % N);
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        deq   = load & found;
        ptr_d = (win == SW'(N - 1)) ? '0 : win + SW'(1);
        head  = mem_q[win][rptr_q[win]];
    end

    assign bus.in_enq_rdy  = rdy;
    assign bus.out_enq_ena = (state_q == ST_VALID);
    assign bus.out_enq_v   = data_q;
    assign bus.out_src     = src_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (enq[i]) mem_q[i][wptr_q[i]] <= bus.in_enq_v[i*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            ptr_q   <= '0;
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (enq[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
                if (deq && win == SW'(i)) rptr_q[i] <= rptr_q[i] + PW'(1);
                case ({enq[i], deq && (win == SW'(i))})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
            if (load) begin
                if (found) begin
                    state_q <= ST_VALID;
                    data_q  <= head;
                    src_q   <= win;
                    if (!prio_hit) ptr_q <= ptr_d;
                end else begin
                    state_q <= ST_EMPTY;
                end
            end
        end
    end
endmodule
